beat_sequencer: RTL and testbench
=================================

Name: beat_sequencer

Overview:
Upstream stage that drives the two-voice music ROM. It generates the beat-index stream (`ibeat_num`), the voice/track select (`en`) and a mute flag from a free-running system clock. Debounced one-pulse buttons and a loop switch control playback. The music ROM is purely combinational; this block owns all timing, play/pause/stop and loop control.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- TICK_HZ, 32, beat-index advance rate in Hz (16 indices per musical beat at 120 BPM).
- BEAT_LEN, 128, number of indices in one pass of the song; must be < 2**CNT_W.
- CNT_W, 12, width of `ibeat_num`.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- play_pause  in  1  single-cycle pulse; start, pause or resume playback
- stop  in  1  single-cycle pulse; abort playback and return to idle
- loop_en  in  1  level; 1 = wrap to 0 at end of song, 0 = one-shot
- track_sel  in  1  level; voice select, latched at start
- ibeat_num  out  CNT_W  beat index to the ROM
- en  out  1  latched track select to the ROM
- mute  out  1  1 = downstream must output silence
- beat_tick  out  1  one-cycle pulse on each index advance
- done  out  1  one-cycle pulse when a one-shot pass completes

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous, active-high. All outputs are registered.
- Reset values: state IDLE, ibeat_num=BEAT_LEN (silent index), en=0, mute=1, beat_tick=0, done=0, divider=0.
- Divider: DIV = CLK_FREQ/TICK_HZ, counter width $clog2(DIV).
  - Counts only in PLAY.
  - Holds in PAUSE.
  - Cleared in IDLE and DONE, and on any entry to PLAY from IDLE or DONE.
  - Terminal count is DIV-1; on terminal the counter returns to 0.
- States IDLE, PLAY, PAUSE, DONE:
  - IDLE --play_pause--> PLAY: ibeat_num=0, divider=0, en<=track_sel, mute=0.
  - PLAY --play_pause--> PAUSE: ibeat_num and divider hold, mute=1.
  - PAUSE --play_pause--> PLAY: resume from the held divider and index, mute=0.
  - DONE --play_pause--> PLAY: same as from IDLE.
  - Any state --stop--> IDLE: ibeat_num=BEAT_LEN, mute=1, divider cleared.
- Tick in PLAY: when the divider reaches terminal, beat_tick=1 for the next cycle and ibeat_num advances.
  - If ibeat_num==BEAT_LEN-1 and loop_en=1: ibeat_num becomes 0; state stays PLAY; en is unchanged.
  - If ibeat_num==BEAT_LEN-1 and loop_en=0: state becomes DONE, ibeat_num=BEAT_LEN, mute=1, done=1 for one cycle.
  - Otherwise: ibeat_num+1.
- Priorities:
  - stop beats play_pause in the same cycle.
  - play_pause beats a tick in the same cycle: the tick is dropped and the index does not advance.
- loop_en is sampled only at the wrap point.
- track_sel changes during PLAY/PAUSE are ignored until the next start.
- Latency: 1 cycle from a play_pause/stop pulse to the state/output change.
- mute is derived from the next state and registered, so it is valid in the same cycle as the state change.

Optional Feature:
TEMPO_SEL_EN:
- When defined, adds input `tempo_fast` (1 bit, level).
- When tempo_fast=1, the terminal count becomes DIV/2-1, giving double speed.
- The compare is >= terminal, so switching to fast when the divider is already past the new terminal produces a tick on the next cycle.
- When undefined, the port is absent and the terminal count is fixed at DIV-1.

Decomposition:
- Package `music_pkg`: state enum (IDLE/PLAY/PAUSE/DONE), default TICK_HZ, BEAT_LEN, CNT_W and the silent-index constant. The ROM shares the same BEAT_LEN.
- Sub-module `tick_gen`: parameterised divider with run/clear inputs, a tick output and the optional fast input. Instantiated once.

Test Plan (bench uses CLK_FREQ=64, TICK_HZ=16, so DIV=4; BEAT_LEN=8):
1. Reset mid-PLAY at ibeat_num=5 -> outputs asynchronously return to ibeat_num=8, mute=1, en=0, state IDLE.
2. track_sel=1, then play_pause -> next cycle en=1, mute=0, ibeat_num=0; beat_tick every 4 cycles; ibeat_num steps 0..7.
3. loop_en=0, run to index 7 -> next tick gives done=1 for 1 cycle, ibeat_num=8, mute=1. Repeat with loop_en=1 -> ibeat_num=0, done stays 0.
4. play_pause at index 3 with the divider at 2; wait 20 cycles; play_pause again -> the tick to 4 arrives exactly 1 divider count (2 cycles) after resume.
5. play_pause and stop asserted together in PLAY -> IDLE, ibeat_num=8. play_pause coincident with a tick -> PAUSE with the index unchanged.
6. TEMPO_SEL_EN defined, tempo_fast=1 -> beat_tick period 2 cycles. Assert tempo_fast while the divider is at 3 -> tick on the next cycle.

Source files
------------

// File: rtl/music_pkg.sv
// Shared types and defaults for the beat sequencer and the music ROM it drives.
package music_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StPause,
        StDone
    } state_e;

    localparam int unsigned DEF_CLK_FREQ = 100_000_000;
    localparam int unsigned DEF_TICK_HZ  = 32;
    localparam int unsigned DEF_BEAT_LEN = 128;
    localparam int unsigned DEF_CNT_W    = 12;

    // The ROM treats index BEAT_LEN as the silent entry.
    localparam int unsigned DEF_SILENT_IDX = DEF_BEAT_LEN;

    function automatic int unsigned div_ratio(input int unsigned clk_freq,
                                              input int unsigned tick_hz);
        return (tick_hz == 0) ? 1 : ((clk_freq / tick_hz == 0) ? 1 : clk_freq / tick_hz);
    endfunction

endpackage

// File: rtl/beat_sequencer_if.sv
// Control and ROM-side signals of the beat sequencer.
// TEMPO_SEL_EN adds the tempo_fast level input.
interface beat_sequencer_if #(
    parameter int unsigned CNT_W = 12
);
    logic             play_pause;
    logic             stop;
    logic             loop_en;
    logic             track_sel;
`ifdef TEMPO_SEL_EN
    logic             tempo_fast;
`endif
    logic [CNT_W-1:0] ibeat_num;
    logic             en;
    logic             mute;
    logic             beat_tick;
    logic             done;

`ifdef TEMPO_SEL_EN
    modport master (
        output play_pause, stop, loop_en, track_sel, tempo_fast,
        input  ibeat_num, en, mute, beat_tick, done
    );
    modport slave (
        input  play_pause, stop, loop_en, track_sel, tempo_fast,
        output ibeat_num, en, mute, beat_tick, done
    );
`else
    modport master (
        output play_pause, stop, loop_en, track_sel,
        input  ibeat_num, en, mute, beat_tick, done
    );
    modport slave (
        input  play_pause, stop, loop_en, track_sel,
        output ibeat_num, en, mute, beat_tick, done
    );
`endif

endinterface

// File: rtl/tick_gen.sv
// Clock divider producing a tick when the count reaches terminal.
// TEMPO_SEL_EN adds i_fast, which halves the terminal count.
module tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_clear,
`ifdef TEMPO_SEL_EN
    input  logic i_fast,
`endif
    output logic o_tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] TERM_SLOW = W'(DIV - 1);
`ifdef TEMPO_SEL_EN
    localparam logic [W-1:0] TERM_FAST = W'((DIV >= 2) ? (DIV / 2 - 1) : 0);
`endif

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_term;

`ifdef TEMPO_SEL_EN
    assign w_term = i_fast ? TERM_FAST : TERM_SLOW;
`else
    assign w_term = TERM_SLOW;
`endif

    // >= so that switching to fast past the new terminal ticks right away.
    assign o_tick = i_run && (r_cnt >= w_term);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run) begin
            if (o_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/beat_sequencer.sv
// Play/pause/stop/loop control and beat-index generation for the music ROM.
// TEMPO_SEL_EN enables the double-speed tempo_fast input.
module beat_sequencer
    import music_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned TICK_HZ  = DEF_TICK_HZ,
    parameter int unsigned BEAT_LEN = DEF_BEAT_LEN,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input logic               clk,
    input logic               rst,
    beat_sequencer_if.slave   io_bus
);

    localparam int unsigned      DIV        = div_ratio(CLK_FREQ, TICK_HZ);
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(BEAT_LEN - 1);
    localparam logic [CNT_W-1:0] SILENT_IDX = CNT_W'(BEAT_LEN);

    state_e           r_state;
    logic [CNT_W-1:0] r_ibeat_num;
    logic             r_en;
    logic             r_mute;
    logic             r_beat_tick;
    logic             r_done;

    logic w_tick;
    logic w_run;
    logic w_clear;

    // A pulse in the same cycle as a terminal count wins, so the divider must not advance.
    assign w_run   = (r_state == StPlay) && !io_bus.play_pause && !io_bus.stop;
    assign w_clear = io_bus.stop || (r_state == StIdle) || (r_state == StDone);

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .i_run   (w_run),
        .i_clear (w_clear),
`ifdef TEMPO_SEL_EN
        .i_fast  (io_bus.tempo_fast),
`endif
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_ibeat_num <= SILENT_IDX;
            r_en        <= 1'b0;
            r_mute      <= 1'b1;
            r_beat_tick <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_beat_tick <= 1'b0;
            r_done      <= 1'b0;
            if (io_bus.stop) begin
                r_state     <= StIdle;
                r_ibeat_num <= SILENT_IDX;
                r_mute      <= 1'b1;
            end else if (io_bus.play_pause) begin
                unique case (r_state)
                    StIdle, StDone: begin
                        r_state     <= StPlay;
                        r_ibeat_num <= '0;
                        r_en        <= io_bus.track_sel;
                        r_mute      <= 1'b0;
                    end
                    StPlay: begin
                        r_state <= StPause;
                        r_mute  <= 1'b1;
                    end
                    StPause: begin
                        r_state <= StPlay;
                        r_mute  <= 1'b0;
                    end
                    default: begin
                        r_state <= StIdle;
                        r_mute  <= 1'b1;
                    end
                endcase
            end else if (w_tick) begin
                r_beat_tick <= 1'b1;
                if (r_ibeat_num == LAST_IDX) begin
                    if (io_bus.loop_en) begin
                        r_ibeat_num <= '0;
                    end else begin
                        r_state     <= StDone;
                        r_ibeat_num <= SILENT_IDX;
                        r_mute      <= 1'b1;
                        r_done      <= 1'b1;
                    end
                end else begin
                    r_ibeat_num <= r_ibeat_num + 1'b1;
                end
            end
        end
    end

    assign io_bus.ibeat_num = r_ibeat_num;
    assign io_bus.en        = r_en;
    assign io_bus.mute      = r_mute;
    assign io_bus.beat_tick = r_beat_tick;
    assign io_bus.done      = r_done;

endmodule

// File: tb/tb_beat_sequencer.sv
// Self-checking bench for beat_sequencer: vector table, corner sequences, random vs model.
// Define TEMPO_SEL_EN to also exercise the tempo_fast input.
module tb_beat_sequencer;

    localparam int unsigned CLK_FREQ = 64;
    localparam int unsigned TICK_HZ  = 16;
    localparam int unsigned BEAT_LEN = 8;
    localparam int unsigned CNT_W    = 12;
    localparam int          DIV      = CLK_FREQ / TICK_HZ;
    localparam int          SILENT   = BEAT_LEN;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    beat_sequencer_if #(.CNT_W(CNT_W)) bus ();

    beat_sequencer #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (TICK_HZ),
        .BEAT_LEN (BEAT_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: 0 idle, 1 playing, 2 paused, 3 finished.
    int m_state, m_idx, m_phase;
    bit m_en, m_tick, m_done, m_fast;

    typedef struct {
        bit pp; bit st; bit le; bit ts;
        int idx; bit en; bit mute; bit tick; bit done;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(bit pp, bit st, bit le, bit ts,
                                int idx, bit en, bit mute, bit tick, bit done);
        vec_t v;
        v.pp = pp; v.st = st; v.le = le; v.ts = ts;
        v.idx = idx; v.en = en; v.mute = mute; v.tick = tick; v.done = done;
        return v;
    endfunction

    function automatic void model_reset();
        m_state = 0; m_idx = SILENT; m_phase = 0;
        m_en = 0; m_tick = 0; m_done = 0;
    endfunction

    function automatic void model_step(bit pp, bit st, bit le, bit ts);
        int period;
        period = m_fast ? DIV / 2 : DIV;
        m_tick = 0;
        m_done = 0;
        if (st) begin
            m_state = 0; m_idx = SILENT; m_phase = 0;
        end else if (pp) begin
            if (m_state == 0 || m_state == 3) begin
                m_state = 1; m_idx = 0; m_phase = 0; m_en = ts;
            end else if (m_state == 1) begin
                m_state = 2;
            end else begin
                m_state = 1;
            end
        end else if (m_state == 1) begin
            // m_phase counts elapsed play cycles within the current index.
            if (m_phase + 1 >= period) begin
                m_phase = 0;
                m_tick  = 1;
                if (m_idx == BEAT_LEN - 1) begin
                    if (le) m_idx = 0;
                    else begin
                        m_state = 3; m_idx = SILENT; m_done = 1;
                    end
                end else begin
                    m_idx = m_idx + 1;
                end
            end else begin
                m_phase = m_phase + 1;
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input int idx, input bit en, input bit mute,
                           input bit tick, input bit done);
        chk({tag, ".ibeat_num"}, int'(bus.ibeat_num), idx);
        chk({tag, ".en"}, int'(bus.en), int'(en));
        chk({tag, ".mute"}, int'(bus.mute), int'(mute));
        chk({tag, ".beat_tick"}, int'(bus.beat_tick), int'(tick));
        chk({tag, ".done"}, int'(bus.done), int'(done));
    endtask

    task automatic chk_model(input string tag);
        chk_out(tag, m_idx, m_en, m_state != 1, m_tick, m_done);
    endtask

    // Called at a falling edge: drive, clock once, return at the next falling edge.
    task automatic cycle(input bit pp, input bit st, input bit le, input bit ts);
        bus.play_pause = pp;
        bus.stop       = st;
        bus.loop_en    = le;
        bus.track_sel  = ts;
        @(posedge clk);
        model_step(pp, st, le, ts);
        @(negedge clk);
        bus.play_pause = 1'b0;
        bus.stop       = 1'b0;
    endtask

    initial begin
        vec_t v;
        bus.play_pause = 1'b0;
        bus.stop       = 1'b0;
        bus.loop_en    = 1'b0;
        bus.track_sel  = 1'b0;
`ifdef TEMPO_SEL_EN
        bus.tempo_fast = 1'b0;
`endif
        m_fast = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_out("reset", SILENT, 0, 1, 0, 0);
        rst = 1'b0;
        model_reset();

        // One-shot pass with track_sel dropped mid-play, then a looping pass.
        vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 0));
        for (int k = 1; k <= 32; k++)
            vecs.push_back(mk(0, 0, 0, k < 2, (k == 32) ? SILENT : k / 4, 1, k == 32,
                              (k % 4) == 0, k == 32));
        vecs.push_back(mk(0, 0, 0, 0, SILENT, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 36; k++)
            vecs.push_back(mk(0, 0, 1, 1, (k / 4) % 8, 0, 0, (k % 4) == 0, 0));
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            cycle(v.pp, v.st, v.le, v.ts);
            chk_out($sformatf("vec%0d", i), v.idx, v.en, v.mute, v.tick, v.done);
        end

        // Asynchronous reset while playing at index 5.
        cycle(0, 1, 0, 1);
        cycle(1, 0, 0, 1);
        repeat (20) cycle(0, 0, 0, 1);
        chk_out("pre_rst", 5, 1, 0, 1, 0);
        #2 rst = 1'b1;
        #1 chk_out("async_rst", SILENT, 0, 1, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(0, 0, 0, 1);
        chk_out("idle_hold", SILENT, 0, 1, 0, 0);

        // Pause at index 3 with the divider at 2, resume after 20 cycles.
        cycle(1, 0, 0, 1);
        chk_out("start", 0, 1, 0, 0, 0);
        repeat (14) cycle(0, 0, 0, 0);
        chk_out("at3", 3, 1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk_out("pause", 3, 1, 1, 0, 0);
        repeat (20) cycle(0, 0, 0, 0);
        chk_out("paused20", 3, 1, 1, 0, 0);
        cycle(1, 0, 0, 0);
        chk_out("resume", 3, 1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk_out("resume1", 3, 1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk_out("resume2", 4, 1, 0, 1, 0);

        // stop beats play_pause; play_pause beats a tick.
        cycle(1, 1, 0, 0);
        chk_out("pp_stop", SILENT, 1, 1, 0, 0);
        cycle(1, 0, 0, 0);
        chk_out("restart", 0, 0, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0);
        chk_out("pre_tick", 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk_out("pp_on_tick", 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        chk_out("pp_on_tick_hold", 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        chk_out("resume_at_term", 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk_out("tick_after_resume", 1, 0, 0, 1, 0);

`ifdef TEMPO_SEL_EN
        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0);
        bus.tempo_fast = 1'b1;
        m_fast = 1;
        cycle(0, 0, 0, 0);
        chk_out("fast_late", 1, 0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        chk_out("fast_a", 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk_out("fast_b", 2, 0, 0, 1, 0);
        repeat (6) begin
            cycle(0, 0, 1, 0);
            chk_model("fast_run");
        end
        bus.tempo_fast = 1'b0;
        m_fast = 0;
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit pp, st, le, ts;
            pp = ($urandom_range(15) == 0);
            st = ($urandom_range(63) == 0);
            le = (i % 400 < 200) ? 1'b0 : ($urandom_range(7) != 0);
            ts = $urandom_range(1);
`ifdef TEMPO_SEL_EN
            if ($urandom_range(31) == 0) begin
                m_fast = ~m_fast;
                bus.tempo_fast = m_fast;
            end
`endif
            cycle(pp, st, le, ts);
            chk_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
